// File: rtl/nco_interp_ctrl.sv
// Gardner timing-recovery interpolation controller: loop-filter error steers a
// decrementing modulo-1 NCO whose underflows emit interpolation strobes and mu.
module nco_interp_ctrl #(
   parameter int unsigned      NCO_W    = 32,
   parameter logic [NCO_W-1:0] W_NOM    = 32'h8000_0000,
   parameter logic [NCO_W-1:0] W_MIN    = 32'h7000_0000,
   parameter logic [NCO_W-1:0] W_MAX    = 32'h9000_0000,
   parameter int unsigned      FE_SHIFT = 0,
   parameter logic [NCO_W-1:0] ETA_INIT = 32'hFFFF_FFFF,
   parameter int unsigned      MU_SHIFT = 1,
   parameter int unsigned      MU_W     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [NCO_W-1:0] fe,
   input  logic                    loop_out_en,
   input  logic                    sample_en,
   output logic                    strobe,
   output logic [MU_W-1:0]         mu,
   output logic                    sym_strobe,
   output logic                    mid_strobe,
   output logic                    w_clamped
);

   localparam int unsigned WR_W  = NCO_W + 2;
   localparam int unsigned MUX_W = NCO_W + MU_SHIFT;

   logic signed [NCO_W-1:0] fe_p0;
   logic signed [NCO_W-1:0] fe_sh;
   logic signed [WR_W-1:0]  w_raw;
   logic [NCO_W-1:0]        w_p1;
   logic [NCO_W-1:0]        eta;
   logic [NCO_W:0]          diff;
   logic                    borrow;
   logic                    phase;

   function automatic logic [NCO_W-1:0] clamp_w(input logic signed [WR_W-1:0] x);
      if (x < $signed({2'b00, W_MIN}))
         return W_MIN;
      if (x > $signed({2'b00, W_MAX}))
         return W_MAX;
      return x[NCO_W-1:0];
   endfunction

   function automatic logic out_of_range(input logic signed [WR_W-1:0] x);
      return (x < $signed({2'b00, W_MIN})) || (x > $signed({2'b00, W_MAX}));
   endfunction

   // mu is the residual eta scaled by SPS; any bit pushed past the MSB saturates
   function automatic logic [MU_W-1:0] sat_mu(input logic [NCO_W-1:0] eta_pre);
      logic [MUX_W-1:0] ext;
      ext = MUX_W'(eta_pre) << MU_SHIFT;
      if ((ext >> NCO_W) != '0)
         return '1;
      return ext[NCO_W-1 -: MU_W];
   endfunction

   assign fe_sh  = fe_p0 >>> FE_SHIFT;
   assign w_raw  = $signed({2'b00, W_NOM}) + $signed({{2{fe_sh[NCO_W-1]}}, fe_sh});
   assign diff   = {1'b0, eta} - {1'b0, w_p1};
   assign borrow = diff[NCO_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         fe_p0      <= '0;
         w_p1       <= W_NOM;
         w_clamped  <= 1'b0;
         eta        <= ETA_INIT;
         phase      <= 1'b0;
         strobe     <= 1'b0;
         sym_strobe <= 1'b0;
         mid_strobe <= 1'b0;
         mu         <= '0;
      end else begin
         // stage p0: capture loop-filter error
         if (loop_out_en)
            fe_p0 <= fe;
         // stage p1: control word, one edge behind the captured error
         w_p1      <= clamp_w(w_raw);
         w_clamped <= out_of_range(w_raw);
         // NCO step and strobe generation use the word already in w_p1
         strobe     <= 1'b0;
         sym_strobe <= 1'b0;
         mid_strobe <= 1'b0;
         if (sample_en) begin
            eta <= diff[NCO_W-1:0];
            if (borrow) begin
               strobe     <= 1'b1;
               sym_strobe <= ~phase;
               mid_strobe <= phase;
               mu         <= sat_mu(eta);
               phase      <= ~phase;
            end
         end
      end
   end

endmodule

// File: tb/tb_nco_interp_ctrl.sv
// Scoreboard bench for nco_interp_ctrl: stimulus queues hand-derived strobes,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_nco_interp_ctrl;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [31:0] fe = '0;
   logic               loop_out_en = 1'b0;
   logic               sample_en = 1'b0;
   logic               strobe, sym_strobe, mid_strobe, w_clamped;
   logic [15:0]        mu;
   logic               strobe2, sym_strobe2, mid_strobe2, w_clamped2;
   logic [15:0]        mu2;

   nco_interp_ctrl dut (
      .clk(clk), .reset(reset), .fe(fe), .loop_out_en(loop_out_en),
      .sample_en(sample_en), .strobe(strobe), .mu(mu), .sym_strobe(sym_strobe),
      .mid_strobe(mid_strobe), .w_clamped(w_clamped)
   );

   // second instance starts at eta=0x4000_0000 so its first underflow gives mu=0x8000
   nco_interp_ctrl #(.ETA_INIT(32'h4000_0000)) dut2 (
      .clk(clk), .reset(reset), .fe(fe), .loop_out_en(loop_out_en),
      .sample_en(sample_en), .strobe(strobe2), .mu(mu2), .sym_strobe(sym_strobe2),
      .mid_strobe(mid_strobe2), .w_clamped(w_clamped2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [15:0] mu;
      logic        sym;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_pass = 0;
   int   n_chk = 0;
   int   base = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input logic [15:0] m, input logic s);
      exp_t e;
      e.cyc = base + c;
      e.mu  = m;
      e.sym = s;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (strobe === 1'b1) begin
         n_chk++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_strobe: got strobe at cycle %0d mu=0x%h, expected none",
                     cyc - base, mu);
         end else begin
            mon_e = q.pop_front();
            if (cyc == mon_e.cyc && mu === mon_e.mu && sym_strobe === mon_e.sym &&
                mid_strobe === ~mon_e.sym)
               n_pass++;
            else
               $display("FAIL strobe_seq: got cycle %0d mu=0x%h sym=%b mid=%b, expected cycle %0d mu=0x%h sym=%b mid=%b",
                        cyc - base, mu, sym_strobe, mid_strobe,
                        mon_e.cyc - base, mon_e.mu, mon_e.sym, ~mon_e.sym);
         end
      end
   end

   initial begin
      // reset with inputs active: reset must dominate
      reset = 1'b1;
      sample_en = 1'b1;
      loop_out_en = 1'b1;
      fe = 32'sh1234_5678;
      tick();
      tick();
      base = cyc;
      loop_out_en = 1'b0;
      fe = '0;
      chk("reset_flags", 32'({strobe, sym_strobe, mid_strobe, w_clamped}), 32'h0);
      chk("reset_mu", 32'(mu), 32'h0);

      // nominal word: strobes every 2 samples, mu saturated, tags alternate
      reset = 1'b0;
      push(2, 16'hFFFF, 1'b1);
      push(4, 16'hFFFF, 1'b0);
      push(6, 16'hFFFF, 1'b1);
      push(8, 16'hFFFF, 1'b0);
      tick();
      chk("dut2_mu", 32'(mu2), 32'h8000);
      chk("dut2_tags", 32'({strobe2, sym_strobe2, mid_strobe2}), 32'b110);
      repeat (7) tick();

      // 5-cycle sample gap: everything frozen, then the same pattern shifted by 5
      sample_en = 1'b0;
      repeat (5) tick();
      chk("pause_mu_hold", 32'(mu), 32'hFFFF);
      chk("pause_no_strobe", 32'(strobe), 32'h0);
      sample_en = 1'b1;
      push(15, 16'hFFFF, 1'b1);
      push(17, 16'hFFFF, 1'b0);
      repeat (4) tick();

      // fe = -0x1000_0000 -> w = 0x7000_0000 exactly at the lower bound
      sample_en = 1'b0;
      fe = -32'sh1000_0000;
      loop_out_en = 1'b1;
      tick();
      loop_out_en = 1'b0;
      tick();
      chk("w_min_bound_not_clamped", 32'(w_clamped), 32'h0);
      sample_en = 1'b1;
      push(22, 16'h3FFF, 1'b1);
      push(24, 16'h7FFF, 1'b0);
      push(26, 16'hBFFF, 1'b1);
      push(29, 16'h1FFF, 1'b0);
      push(31, 16'h5FFF, 1'b1);
      push(33, 16'h9FFF, 1'b0);
      push(35, 16'hDFFF, 1'b1);
      repeat (16) tick();

      // fe = +0x2000_0000 -> clamp high to 0x9000_0000, flag one edge after fe_reg
      sample_en = 1'b0;
      fe = 32'sh2000_0000;
      loop_out_en = 1'b1;
      tick();
      loop_out_en = 1'b0;
      chk("clamp_hi_not_yet", 32'(w_clamped), 32'h0);
      tick();
      chk("clamp_hi", 32'(w_clamped), 32'h1);
      sample_en = 1'b1;
      push(39, 16'hDFFF, 1'b0);
      push(41, 16'h9FFF, 1'b1);
      push(43, 16'h5FFF, 1'b0);
      push(45, 16'h1FFF, 1'b1);
      push(46, 16'hFFFF, 1'b0);
      push(48, 16'hBFFF, 1'b1);
      push(50, 16'h7FFF, 1'b0);
      push(52, 16'h3FFF, 1'b1);
      push(53, 16'hFFFF, 1'b0);
      repeat (16) tick();

      // upper bound exactly, then clamp low
      sample_en = 1'b0;
      fe = 32'sh1000_0000;
      loop_out_en = 1'b1;
      tick();
      loop_out_en = 1'b0;
      chk("bound_prev_clamped", 32'(w_clamped), 32'h1);
      tick();
      chk("w_max_bound_not_clamped", 32'(w_clamped), 32'h0);
      fe = -32'sh2000_0000;
      loop_out_en = 1'b1;
      tick();
      loop_out_en = 1'b0;
      chk("clamp_lo_not_yet", 32'(w_clamped), 32'h0);
      tick();
      chk("clamp_lo", 32'(w_clamped), 32'h1);
      sample_en = 1'b1;
      push(60, 16'h3FFF, 1'b1);
      repeat (4) tick();

      // reset on the edge where the next underflow would land
      reset = 1'b1;
      tick();
      chk("reset_abort_flags", 32'({strobe, sym_strobe, mid_strobe, w_clamped}), 32'h0);
      chk("reset_abort_mu", 32'(mu), 32'h0);
      reset = 1'b0;
      push(64, 16'hFFFF, 1'b1);
      push(66, 16'hFFFF, 1'b0);
      repeat (4) tick();
      sample_en = 1'b0;
      repeat (2) tick();

      n_chk++;
      if (q.size() == 0)
         n_pass++;
      else
         $display("FAIL missing_strobes: got %0d strobes outstanding, expected 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
